// File: rtl/divider.sv
// Sequential signed 32-bit non-restoring divider: one add/subtract step per cycle.
// Define DIVIDER_REMAINDER_EN to add the data_remainder port and remainder correction.
module divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
`ifdef DIVIDER_REMAINDER_EN
    output logic [31:0] data_remainder,
`endif
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    // Handshake: ctrl_DIV is a fire-and-forget start (no ready), sampled in any
    // state; data_resultRDY pulses once per completed, non-aborted operation.
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      r_state;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_exc;
    logic [32:0] r_q;
    logic [32:0] r_d;
    logic [32:0] r_p;
    logic [4:0]  r_cnt;

    logic [32:0] w_a_ext;
    logic [32:0] w_b_ext;
    logic [32:0] w_abs_a;
    logic [32:0] w_abs_b;
    logic        w_div0;
    logic        w_ovf;
    logic [32:0] w_p_sh;
    logic [32:0] w_p_new;
    logic [32:0] w_q_next;
    logic [32:0] w_q_neg;
    logic [31:0] w_quot;
    logic        w_exc_done;

    assign w_a_ext  = {data_operandA[31], data_operandA};
    assign w_b_ext  = {data_operandB[31], data_operandB};
    assign w_abs_a  = data_operandA[31] ? -w_a_ext : w_a_ext;
    assign w_abs_b  = data_operandB[31] ? -w_b_ext : w_b_ext;
    assign w_div0   = (data_operandB == 32'h0000_0000);
    assign w_ovf    = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);

    // The dividend magnitude lives in Q[31:0]; its MSB feeds P on each shift.
    assign w_p_sh   = {r_p[31:0], r_q[31]};
    assign w_p_new  = r_p[32] ? (w_p_sh + r_d) : (w_p_sh - r_d);
    assign w_q_next = {r_q[31:0], ~w_p_new[32]};
    assign w_q_neg  = -r_q;
    assign w_quot   = (r_sign_a ^ r_sign_b) ? w_q_neg[31:0] : r_q[31:0];

    // An exception start parks in DONE for one cycle, then publishes its result.
    assign w_exc_done = (r_state == DONE) && r_exc;

`ifdef DIVIDER_REMAINDER_EN
    logic [32:0] w_p_fix;
    logic [32:0] w_r_neg;
    logic [31:0] w_rem;

    assign w_p_fix = r_p[32] ? (r_p + r_d) : r_p;
    assign w_r_neg = -w_p_fix;
    assign w_rem   = r_sign_a ? w_r_neg[31:0] : w_p_fix[31:0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_sign_a       <= 1'b0;
            r_sign_b       <= 1'b0;
            r_exc          <= 1'b0;
            r_q            <= '0;
            r_d            <= '0;
            r_p            <= '0;
            r_cnt          <= '0;
            data_result    <= '0;
`ifdef DIVIDER_REMAINDER_EN
            data_remainder <= '0;
`endif
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;

            if (w_exc_done) begin
                data_result    <= r_q[31:0];
`ifdef DIVIDER_REMAINDER_EN
                data_remainder <= '0;
`endif
                data_exception <= 1'b1;
                data_resultRDY <= 1'b1;
            end

            if (ctrl_DIV) begin
                r_sign_a <= data_operandA[31];
                r_sign_b <= data_operandB[31];
                r_d      <= w_abs_b;
                r_p      <= '0;
                r_cnt    <= '0;
                if (w_div0 || w_ovf) begin
                    r_exc   <= 1'b1;
                    r_q     <= w_ovf ? 33'h0_8000_0000 : 33'h0_0000_0000;
                    r_state <= DONE;
                    busy    <= 1'b0;
                end else begin
                    r_exc   <= 1'b0;
                    r_q     <= w_abs_a;
                    r_state <= ITER;
                    busy    <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    ITER: begin
                        r_p   <= w_p_new;
                        r_q   <= w_q_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= FIX;
                        end
                    end
                    FIX: begin
                        data_result    <= w_quot;
`ifdef DIVIDER_REMAINDER_EN
                        data_remainder <= w_rem;
`endif
                        data_exception <= 1'b0;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        r_state        <= DONE;
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table plus restart/reset corner sequences.
module tb_divider;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
`ifdef DIVIDER_REMAINDER_EN
    logic [31:0] data_remainder;
`endif
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    divider dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
`ifdef DIVIDER_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    logic [64:0] exp_q[$];   // {exc, quotient, remainder}
    int n_checks = 0;
    int n_pass   = 0;
    int rdy_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        if (b == 32'd0) begin
            v.q = 32'd0; v.r = 32'd0; v.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.q = 32'h8000_0000; v.r = 32'd0; v.exc = 1'b1;
        end else begin
            v.q = $signed(a) / $signed(b);
            v.r = $signed(a) % $signed(b);
            v.exc = 1'b0;
        end
        return v;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (data_resultRDY) begin
            logic [64:0] e;
            rdy_pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rdy: got pulse with result %h, expected no pulse", data_result);
            end else begin
                e = exp_q.pop_front();
                check("result", data_result, e[63:32]);
                check("exception", {31'd0, data_exception}, {31'd0, e[64]});
`ifdef DIVIDER_REMAINDER_EN
                check("remainder", data_remainder, e[31:0]);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Counts edges after the start edge until data_resultRDY is seen (bounded).
    task automatic wait_rdy(output int lat, output int busy_n, output logic busy_at_rdy);
        lat = 0;
        busy_n = 0;
        busy_at_rdy = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                busy_at_rdy = busy;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_q.push_back({v.exc, v.q, v.r});
    endtask

    initial begin
        int lat;
        int busy_n;
        logic busy_rdy;
        int pulses_before;
        logic ok;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[2]  = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
        vecs[3]  = '{32'd5,          32'd0,          32'd0,          32'd0,          1'b1};
        vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b1};
        vecs[5]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
        vecs[6]  = '{32'd6,          32'd4,          32'd1,          32'd2,          1'b0};
        vecs[7]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[8]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
        vecs[9]  = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001,  32'd0,          1'b0};
        vecs[10] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
        vecs[11] = '{32'd1,          32'h8000_0000,  32'd0,          32'd1,          1'b0};
        for (int i = 12; i < NVEC; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 1000);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            vecs[i] = model(ra, rb);
        end

        reset = 1'b1;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("reset_result", data_result, 32'd0);
        check("reset_ctl", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
`ifdef DIVIDER_REMAINDER_EN
        check("reset_remainder", data_remainder, 32'd0);
`endif

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            push_exp(vecs[i]);
            start(vecs[i].a, vecs[i].b);
            wait_rdy(lat, busy_n, busy_rdy);
            check("latency", lat, vecs[i].exc ? 32'd1 : 32'd33);
            check("busy_cycles", busy_n, vecs[i].exc ? 32'd0 : 32'd32);
            check("busy_at_rdy", {31'd0, busy_rdy}, 32'd0);
            ok = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(posedge clock);
                #1;
                if (data_resultRDY || data_result !== vecs[i].q || data_exception !== vecs[i].exc)
                    ok = 1'b0;
            end
            check("hold", {31'd0, ok}, 32'd1);
        end

        // Restart mid-operation: 100/7 aborted by 9/3 on E10
        pulses_before = rdy_pulses;
        start(32'd100, 32'd7);
        repeat (8) @(negedge clock);
        push_exp(model(32'd9, 32'd3));
        start(32'd9, 32'd3);
        wait_rdy(lat, busy_n, busy_rdy);
        check("restart_latency", lat, 32'd33);
        repeat (5) @(negedge clock);
        check("restart_pulses", rdy_pulses - pulses_before, 32'd1);

        // ctrl_DIV high during DONE: pulse still occurs and a new op begins
        pulses_before = rdy_pulses;
        push_exp(model(32'd100, 32'd7));
        push_exp(model(32'hFFFF_FF9C, 32'd9));
        start(32'd100, 32'd7);
        wait_rdy(lat, busy_n, busy_rdy);
        check("b2b_first_latency", lat, 32'd33);
        start(32'hFFFF_FF9C, 32'd9);
        wait_rdy(lat, busy_n, busy_rdy);
        check("b2b_second_latency", lat, 32'd33);
        repeat (3) @(negedge clock);
        check("b2b_pulses", rdy_pulses - pulses_before, 32'd2);

        // Reset mid-operation on E20: nothing produced, outputs cleared
        pulses_before = rdy_pulses;
        start(32'd1000, 32'd3);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("reset_mid_pulses", rdy_pulses - pulses_before, 32'd0);
        check("reset_mid_result", data_result, 32'd0);
        check("reset_mid_ctl", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
`ifdef DIVIDER_REMAINDER_EN
        check("reset_mid_remainder", data_remainder, 32'd0);
`endif
        push_exp('{32'd6, 32'd4, 32'd1, 32'd2, 1'b0});
        start(32'd6, 32'd4);
        wait_rdy(lat, busy_n, busy_rdy);
        check("post_reset_latency", lat, 32'd33);
        repeat (3) @(negedge clock);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
